seq_mult: RTL and testbench
===========================

SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand width in bits (legal range 1..32).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to begin a multiplication; sampled on rising edge of clk.
REQ-005 SHALL have port: sgn  input  1  operand mode; 0 = unsigned, 1 = two's-complement signed; captured with start.
REQ-006 SHALL have port: a  input  WIDTH  multiplicand; captured with start.
REQ-007 SHALL have port: b  input  WIDTH  multiplier; captured with start.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking that product is valid.
REQ-010 SHALL have port: product  output  2*WIDTH  result register.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-012 SHALL, in IDLE or DONE with start=1 at edge k, capture a, b and sgn, clear the internal accumulator, load iteration count WIDTH, and enter BUSY.
REQ-013 SHALL ignore start while in BUSY; captured operands and mode stay unchanged.
REQ-014 SHALL, in BUSY, perform one shift-add iteration per cycle, consuming one multiplier bit LSB-first.
REQ-015 SHALL, in signed mode, operate on operand magnitudes and negate the 2*WIDTH result when exactly one operand is negative; the most-negative value (-2^(WIDTH-1)) SHALL be handled correctly.
REQ-016 SHALL, at edge k+WIDTH, write the final result to product, assert done=1, deassert busy, and enter DONE.
REQ-017 SHALL hold done high for exactly one cycle; DONE SHALL return to IDLE at the next edge unless start=1, in which case the next operation is accepted with no bubble.
REQ-018 SHALL hold product stable from the done pulse until the next completing operation; product SHALL NOT change during BUSY.
REQ-019 SHALL keep busy=1 for exactly the WIDTH cycles after the accepting edge, and busy=0 otherwise.
REQ-020 SHALL make the result exact in 2*WIDTH bits: the unsigned range is 0..(2^WIDTH-1)^2, and the signed range is the full two's-complement product, with no overflow possible.
REQ-021 SHALL, with WIDTH=1 and sgn=0, produce product[0] = a AND b and product[1] = 0.
REQ-022 SHALL produce 0 when a=0 or b=0, with the same latency as any other operation (no early termination).

Reset
REQ-023 SHALL, with rst=1 at a rising edge, force state IDLE, busy=0, done=0, product=0, and clear all internal registers.
REQ-024 SHALL give rst priority over start; an operation in progress SHALL be aborted with no done pulse.
REQ-025 SHALL accept a start on the first edge after rst deasserts.

Verification (WIDTH=4 unless stated)
REQ-026 SHALL verify: unsigned a=3, b=5, start at edge k -> busy high for 4 cycles; done=1 and product=0x0F after edge k+4.
REQ-027 SHALL verify: unsigned 15*15 -> product=0xE1 (225); signed a=-8, b=-8 -> product=0x40 (64); signed a=-3, b=5 -> product=0xF1 (-15).
REQ-028 SHALL verify: start pulsed with new operands during BUSY -> ignored, and the original result is delivered on schedule.
REQ-029 SHALL verify: start held high through DONE -> back-to-back operation accepted, done pulses 5 cycles apart, and busy drops for exactly one cycle between operations.
REQ-030 SHALL verify: rst asserted at cycle 2 of BUSY -> no done pulse, product=0, busy=0, and the next start completes normally.
REQ-031 SHALL verify, with WIDTH=1: all four {a,b} combinations -> product equals {0, a AND b} after 1 BUSY cycle, and the result matches the fault-enumeration golden pattern file.

Source files
------------

// File: rtl/seq_mult.sv
// ---------------------------------------------------------------------------
// seq_mult -- sequential shift-add multiplier, unsigned or two's-complement.
//
// One multiplier bit is consumed per clock (LSB first), so an operation takes
// exactly WIDTH cycles in BUSY regardless of the operand values. Signed
// operands are reduced to magnitudes up front and the final product is
// negated when exactly one operand was negative.
//
// Ports:
//   clk      in   1        rising-edge clock
//   rst      in   1        synchronous, active-high reset
//   start    in   1        begin an operation (accepted in IDLE or DONE)
//   sgn      in   1        0 = unsigned, 1 = signed; captured with start
//   a        in   WIDTH    multiplicand; captured with start
//   b        in   WIDTH    multiplier; captured with start
//   busy     out  1        high for the WIDTH cycles of an operation
//   done     out  1        one-cycle pulse, product valid
//   product  out  2*WIDTH  result register, held until the next completion
// ---------------------------------------------------------------------------
module seq_mult #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [2*WIDTH-1:0] mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [2*WIDTH-1:0] acc_q,     acc_d;
    logic               neg_q,     neg_d;
    logic [CNT_W-1:0]   count_q,   count_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc_sum;

    // Magnitudes fit in WIDTH unsigned bits even for -2^(WIDTH-1): negating
    // that pattern yields the same bits, which read unsigned as 2^(WIDTH-1).
    always_comb begin
        a_neg   = sgn & a[WIDTH-1];
        b_neg   = sgn & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        acc_sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    // Next-state logic. The multiplicand is pre-shifted each cycle so the
    // accumulator only ever adds a full-width value.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a_mag};
                    mplier_d = b_mag;
                    acc_d    = '0;
                    neg_d    = a_neg ^ b_neg;
                    count_d  = CNT_W'(WIDTH);
                    state_d  = S_BUSY;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_BUSY: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q - CNT_W'(1);
                // Last iteration: the result goes straight to the output
                // register so product only changes on the completing edge.
                if (count_q == CNT_W'(1)) begin
                    product_d = neg_q ? -acc_sum : acc_sum;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset clears everything, including the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == S_BUSY);
    assign done    = (state_q == S_DONE);
    assign product = product_q;

endmodule

// File: tb/tb_seq_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_mult -- self-checking bench for seq_mult.
//
// A WIDTH=4 instance is checked every cycle against a timeline model that
// tracks the expected busy/done/product from the operation rules, plus
// directed literal checks. A WIDTH=1 instance is checked against a small
// golden table of all operand combinations.
// ---------------------------------------------------------------------------
module tb_seq_mult;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic       sgn = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;

    logic       start1 = 1'b0;
    logic       sgn1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1;
    logic       done1;
    logic [1:0] product1;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    seq_mult #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    seq_mult #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .start   (start1),
        .sgn     (sgn1),
        .a       (a1),
        .b       (b1),
        .busy    (busy1),
        .done    (done1),
        .product (product1)
    );

    // Plain integer product, truncated to 8 bits.
    function automatic logic [7:0] ref_mult(input logic sg, input logic [3:0] x, input logic [3:0] y);
        int xv;
        int yv;
        xv = (sg && x[3]) ? int'(x) - 16 : int'(x);
        yv = (sg && y[3]) ? int'(y) - 16 : int'(y);
        return 8'(xv * yv);
    endfunction

    // Timeline model: cycles left in the current operation, pending result,
    // and the externally visible values expected after each edge.
    int         remaining = 0;
    logic [7:0] pend_exp = '0;
    logic [7:0] prod_exp = '0;
    bit         done_exp = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            remaining = 0;
            done_exp  = 1'b0;
            prod_exp  = '0;
            pend_exp  = '0;
        end else if (remaining > 0) begin
            remaining = remaining - 1;
            if (remaining == 0) begin
                prod_exp = pend_exp;
                done_exp = 1'b1;
            end else begin
                done_exp = 1'b0;
            end
        end else begin
            done_exp = 1'b0;
            if (start) begin
                pend_exp  = ref_mult(sgn, a, b);
                remaining = 4;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model_busy",    16'(busy),    16'(remaining > 0));
            checkOutput("model_done",    16'(done),    16'(done_exp));
            checkOutput("model_product", 16'(product), 16'(prod_exp));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic st, input logic sg, input logic [3:0] x, input logic [3:0] y);
        start = st;
        sgn   = sg;
        a     = x;
        b     = y;
    endtask

    // Full operation on the WIDTH=4 instance with literal expectations on
    // the busy window, done timing and result.
    task automatic run_op(input string name, input logic sg, input logic [3:0] x, input logic [3:0] y,
                          input logic [7:0] expected);
        applyStimulus(1'b1, sg, x, y);
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput({name, "_busy"}, 16'(busy), 16'd1);
            checkOutput({name, "_nodone"}, 16'(done), 16'd0);
            tick();
        end
        checkOutput({name, "_done"}, 16'(done), 16'd1);
        checkOutput({name, "_idle"}, 16'(busy), 16'd0);
        checkOutput({name, "_prod"}, 16'(product), 16'(expected));
        tick();
        checkOutput({name, "_pulse"}, 16'(done), 16'd0);
        checkOutput({name, "_hold"}, 16'(product), 16'(expected));
    endtask

    logic [1:0] golden1 [4] = '{2'b00, 2'b00, 2'b00, 2'b01};

    initial begin
        logic [1:0] ab;

        tick();
        tick();
        checkOutput("reset_busy", 16'(busy), 16'd0);
        checkOutput("reset_done", 16'(done), 16'd0);
        checkOutput("reset_prod", 16'(product), 16'd0);
        check_en = 1'b1;
        rst = 1'b0;

        // Start on the very first edge after reset release.
        run_op("u3x5",   1'b0, 4'd3,  4'd5,  8'h0F);
        run_op("u15x15", 1'b0, 4'd15, 4'd15, 8'hE1);
        run_op("sm8xm8", 1'b1, 4'h8,  4'h8,  8'h40);
        run_op("sm3x5",  1'b1, 4'hD,  4'd5,  8'hF1);
        run_op("s7xm8",  1'b1, 4'd7,  4'h8,  8'hC8);
        run_op("zero_a", 1'b0, 4'd0,  4'd9,  8'h00);
        run_op("zero_b", 1'b1, 4'hB,  4'd0,  8'h00);

        // New operands pulsed during BUSY must be ignored.
        applyStimulus(1'b1, 1'b0, 4'd7, 4'd9);
        tick();
        start = 1'b0;
        tick();
        applyStimulus(1'b1, 1'b1, 4'd2, 4'd2);
        tick();
        start = 1'b0;
        tick();
        tick();
        checkOutput("ignore_done", 16'(done), 16'd1);
        checkOutput("ignore_prod", 16'(product), 16'h3F);
        tick();

        // Start held through DONE: back-to-back operations, one-cycle gap.
        applyStimulus(1'b1, 1'b0, 4'd2, 4'd3);
        tick();
        applyStimulus(1'b1, 1'b0, 4'd4, 4'd5);
        repeat (4) tick();
        checkOutput("b2b_done1", 16'(done), 16'd1);
        checkOutput("b2b_gap",   16'(busy), 16'd0);
        checkOutput("b2b_prod1", 16'(product), 16'h06);
        tick();
        start = 1'b0;
        checkOutput("b2b_busy2", 16'(busy), 16'd1);
        checkOutput("b2b_nodone", 16'(done), 16'd0);
        repeat (4) tick();
        checkOutput("b2b_done2", 16'(done), 16'd1);
        checkOutput("b2b_prod2", 16'(product), 16'h14);
        tick();

        // Reset during the second BUSY cycle aborts the operation.
        applyStimulus(1'b1, 1'b0, 4'd5, 4'd6);
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        checkOutput("abort_busy", 16'(busy), 16'd0);
        checkOutput("abort_done", 16'(done), 16'd0);
        checkOutput("abort_prod", 16'(product), 16'd0);
        rst = 1'b0;
        run_op("after_rst", 1'b0, 4'd5, 4'd6, 8'h1E);

        // WIDTH=1: every operand combination against the golden table.
        for (int i = 0; i < 4; i++) begin
            ab     = 2'(i);
            a1     = ab[1];
            b1     = ab[0];
            sgn1   = 1'b0;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            checkOutput("w1_busy", 16'(busy1), 16'd1);
            checkOutput("w1_nodone", 16'(done1), 16'd0);
            tick();
            checkOutput("w1_done", 16'(done1), 16'd1);
            checkOutput("w1_idle", 16'(busy1), 16'd0);
            checkOutput("w1_prod", 16'(product1), 16'(golden1[i]));
            tick();
        end

        // WIDTH=1 signed: -1 * -1 = +1.
        a1 = 1'b1;
        b1 = 1'b1;
        sgn1 = 1'b1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        checkOutput("w1_signed", 16'(product1), 16'h1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
